// File: rtl/nmx_pkg.sv
// Shared types and constants for the neuromorphic macro Wishbone arbiter.
package nmx_pkg;

  // Arbiter ownership state; the encoding is internal to the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } nmx_state_e;

  // One-hot owner encoding, as seen on grant_o.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  localparam logic [31:0] NMX_ABORT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned NMX_CNT_W      = 16;

  // Bundled requester-side Wishbone request.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // Map a granted owner to the FSM state it leads to.
  function automatic nmx_state_e owner_state(input logic [1:0] owner);
    case (owner)
      OWNER_M0: return ST_OWN0;
      OWNER_M1: return ST_OWN1;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/nmx_rr_arb2.sv
// Two-way round-robin selector with one bit of history.
module nmx_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was granted last, so requester 0 wins the next tie.
  logic last1_q;

  // Pick the requester; on a tie, the one not granted last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last1_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Remember who was granted whenever a grant is actually taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   last1_q <= 1'b1;
    else if (update_i && |gnt_o)   last1_q <= gnt_o[1];
  end

endmodule

// File: rtl/nmx_wb_arbiter.sv
// Two-requester Wishbone arbiter in front of the neuromorphic macro slave,
// with a no-ack watchdog that aborts a stuck transfer.
module nmx_wb_arbiter
  import nmx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ABORT_DATA     = NMX_ABORT_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o,
  input  logic        clr_timeout_i
);

  localparam logic [NMX_CNT_W-1:0] TO_LAST = NMX_CNT_W'(TIMEOUT_CYCLES - 1);

  nmx_state_e           state_q;
  logic [NMX_CNT_W-1:0] cnt_q;
  logic                 timeout_q, timeout_d;
  logic [1:0]           grant_q;

  wb_req_t    req0, req1, own_req;
  logic       own0, own1, owned, abort;
  logic [1:0] rr_req, rr_gnt;

  assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                  sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
  assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                  sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign owned = own0 | own1;

  // Owner's request; all zero when idle so the slave bus stays quiet.
  always_comb begin
    own_req = '0;
    if (own0)      own_req = req0;
    else if (own1) own_req = req1;
  end

  // Abort fires in the cycle the watchdog has counted out; it overrides any ack.
  assign abort = owned & own_req.stb & (cnt_q == TO_LAST);

  assign s_cyc_o = own_req.cyc & ~abort;
  assign s_stb_o = own_req.stb & ~abort;
  assign s_we_o  = own_req.we;
  assign s_sel_o = own_req.sel;
  assign s_adr_o = own_req.adr;
  assign s_dat_o = own_req.dat;

  assign m0_ack_o = own0 & (abort | s_ack_i);
  assign m1_ack_o = own1 & (abort | s_ack_i);
  assign m0_dat_o = own0 ? (abort ? ABORT_DATA : s_dat_i) : '0;
  assign m1_dat_o = own1 ? (abort ? ABORT_DATA : s_dat_i) : '0;

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  assign rr_req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  nmx_rr_arb2 u_rr (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .req_i    (rr_req),
    .update_i (state_q == ST_IDLE),
    .gnt_o    (rr_gnt)
  );

  // Sticky abort flag: a new abort beats a simultaneous clear.
  always_comb begin
    timeout_d = timeout_q;
    if (abort)              timeout_d = 1'b1;
    else if (clr_timeout_i) timeout_d = 1'b0;
  end

  // Ownership FSM with watchdog counter and registered grant.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      grant_q   <= OWNER_NONE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          grant_q <= rr_gnt;
          state_q <= owner_state(rr_gnt);
        end
        ST_OWN0, ST_OWN1: begin
          if (abort || !own_req.cyc) begin
            state_q <= ST_IDLE;
            grant_q <= OWNER_NONE;
            cnt_q   <= '0;
          end else if (s_ack_i) begin
            cnt_q <= '0;
          end else if (own_req.stb) begin
            cnt_q <= cnt_q + NMX_CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= OWNER_NONE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmx_wb_arbiter.sv
// Self-checking bench for nmx_wb_arbiter: directed scenarios plus a random
// run checked against a transaction-level ownership model.
module tb_nmx_wb_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_adr = 0, m0_dati = 0;
  logic [31:0] m0_dato;
  logic        m0_ack;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_adr = 0, m1_dati = 0;
  logic [31:0] m1_dato;
  logic        m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dato;
  logic [31:0] s_dati = 0;
  logic        s_ack = 0;
  logic [1:0]  grant;
  logic        timeout;
  logic        clr = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nmx_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dati), .m0_dat_o(m0_dato), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dati), .m1_dat_o(m1_dato), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dato), .s_dat_i(s_dati), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(timeout), .clr_timeout_i(clr)
  );

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dati = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dati = 0;
    s_ack = 0; s_dati = 0; clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    s_ack = 1; s_dati = 32'h5555_AAAA;
    m0_cyc = 1; m0_stb = 1;
    #1;
    checks++; if ({grant, timeout} !== 3'b000) begin errors++;
      $display("FAIL rst_grant_to: got %b required 000", {grant, timeout}); end
    checks++; if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dato} !== '0) begin errors++;
      $display("FAIL rst_slave_bus: got cyc=%b stb=%b adr=%h required all 0", s_cyc, s_stb, s_adr); end
    checks++; if ({m0_ack, m1_ack, m0_dato, m1_dato} !== '0) begin errors++;
      $display("FAIL rst_req_side: got ack0=%b ack1=%b dat0=%h required 0", m0_ack, m1_ack, m0_dato); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_write();
    int acks = 0;
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 32'h3000_0000; m0_dati = 32'h0000_00A5;
    #1;
    checks++; if ({grant, s_cyc} !== 3'b000) begin errors++;
      $display("FAIL wr_idle: got grant=%b s_cyc=%b required 00/0", grant, s_cyc); end
    acks += m0_ack;
    @(negedge clk); #1;
    checks++; if ({grant, s_cyc, s_stb, s_we, s_sel} !== {2'b01, 3'b111, 4'hF}) begin errors++;
      $display("FAIL wr_own: got grant=%b cyc/stb/we=%b%b%b sel=%h required 01 111 f", grant, s_cyc, s_stb, s_we, s_sel); end
    checks++; if ({s_adr, s_dato} !== {32'h3000_0000, 32'h0000_00A5}) begin errors++;
      $display("FAIL wr_bus: got adr=%h dat=%h required 30000000 000000a5", s_adr, s_dato); end
    acks += m0_ack;
    @(negedge clk); s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1) begin errors++;
      $display("FAIL wr_ack: got %b required 1", m0_ack); end
    acks += m0_ack;
    @(negedge clk); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    checks++; if ({grant, s_cyc, m0_ack} !== 4'b0100) begin errors++;
      $display("FAIL wr_release: got grant=%b cyc=%b ack=%b required 01 0 0", grant, s_cyc, m0_ack); end
    acks += m0_ack;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL wr_idle_after: got %b required 00", grant); end
    checks++; if (acks !== 1) begin errors++;
      $display("FAIL wr_ack_count: got %0d required 1", acks); end
    clear_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL tie_pre: got %b required 00", grant); end
    @(negedge clk); s_ack = 1; s_dati = 32'h1234_5678; #1;
    checks++; if (grant !== 2'b01) begin errors++;
      $display("FAIL tie_first: got %b required 01", grant); end
    checks++; if ({m0_ack, m0_dato, m1_ack, m1_dato} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0}) begin errors++;
      $display("FAIL tie_route: got a0=%b d0=%h a1=%b d1=%h required 1 12345678 0 0", m0_ack, m0_dato, m1_ack, m1_dato); end
    @(negedge clk); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    checks++; if (grant !== 2'b01) begin errors++;
      $display("FAIL tie_drop: got %b required 01", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL tie_gap: got %b required 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++;
      $display("FAIL tie_second: got %b required 10", grant); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    do_reset();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h3000_0040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0080;
      s_ack = 1; s_dati = 32'h100 + i; #1;
      checks++; if ({grant, m0_ack, m1_ack, m1_dato} !== {2'b10, 1'b0, 1'b1, 32'h100 + i}) begin errors++;
        $display("FAIL b2b_read%0d: got grant=%b a0=%b a1=%b d1=%h required 10 0 1 %h",
                 i, grant, m0_ack, m1_ack, m1_dato, 32'h100 + i); end
      acks += m1_ack;
    end
    @(negedge clk); s_ack = 0; m1_cyc = 0; m1_stb = 0; #1;
    checks++; if ({grant, m0_ack} !== 3'b100) begin errors++;
      $display("FAIL b2b_release: got grant=%b a0=%b required 10 0", grant, m0_ack); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL b2b_gap: got %b required 00", grant); end
    @(negedge clk); #1;
    checks++; if ({grant, s_adr} !== {2'b01, 32'h3000_0080}) begin errors++;
      $display("FAIL b2b_m0_grant: got grant=%b adr=%h required 01 30000080", grant, s_adr); end
    checks++; if (acks !== 4) begin errors++;
      $display("FAIL b2b_ack_count: got %0d required 4", acks); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0004;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      if (k == T) begin s_ack = 1; s_dati = 32'h1111_1111; end
      #1;
      if (k < T) begin
        checks++; if ({m0_ack, s_cyc, timeout} !== 3'b010) begin errors++;
          $display("FAIL to_wait%0d: got ack=%b cyc=%b to=%b required 0 1 0", k, m0_ack, s_cyc, timeout); end
      end else begin
        checks++; if ({m0_ack, m0_dato} !== {1'b1, 32'hDEAD_BEEF}) begin errors++;
          $display("FAIL to_abort: got ack=%b dat=%h required 1 deadbeef", m0_ack, m0_dato); end
        checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++;
          $display("FAIL to_bus_drop: got cyc=%b stb=%b required 00", s_cyc, s_stb); end
      end
    end
    @(negedge clk); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    checks++; if ({grant, timeout} !== 3'b001) begin errors++;
      $display("FAIL to_flag: got grant=%b to=%b required 00 1", grant, timeout); end
    @(negedge clk); clr = 1; #1;
    checks++; if (timeout !== 1'b1) begin errors++;
      $display("FAIL to_sticky: got %b required 1", timeout); end
    @(negedge clk); clr = 0; #1;
    checks++; if (timeout !== 1'b0) begin errors++;
      $display("FAIL to_clear: got %b required 0", timeout); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    @(negedge clk); #1;
    checks++; if ({grant, s_cyc} !== 3'b101) begin errors++;
      $display("FAIL rm_own1: got grant=%b cyc=%b required 10 1", grant, s_cyc); end
    s_ack = 1;
    #1 rst_n = 0;
    #1;
    checks++; if ({s_cyc, m1_ack, grant} !== 4'b0000) begin errors++;
      $display("FAIL rm_async_drop: got cyc=%b a1=%b grant=%b required 0 0 00", s_cyc, m1_ack, grant); end
    @(negedge clk);
    s_ack = 0; m0_cyc = 1; m0_stb = 1; rst_n = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL rm_no_early_grant: got %b required 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++;
      $display("FAIL rm_tie_m0: got %b required 01", grant); end
    clear_inputs();
    @(negedge clk);
  endtask

  // Random traffic against an ownership model: owner 0 = none, 1 = m0, 2 = m1.
  task automatic test_random();
    int owner = 0, last = 2, waited = 0;
    bit flag = 0;
    bit cyc[2], stb[2], we[2];
    logic [3:0]  sel[2];
    logic [31:0] adr[2], dat[2];
    logic [139:0] obs, exp;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit abrt;
      int winner;
      logic [1:0] eg;
      logic       ea[2];
      logic [31:0] ed[2];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cyc[k] = ($urandom_range(0, 3) != 0);
        stb[k] = ($urandom_range(0, 3) != 0);
        we[k]  = $urandom_range(0, 1);
        sel[k] = 4'($urandom);
        adr[k] = $urandom;
        dat[k] = $urandom;
      end
      m0_cyc = cyc[0]; m0_stb = stb[0]; m0_we = we[0]; m0_sel = sel[0]; m0_adr = adr[0]; m0_dati = dat[0];
      m1_cyc = cyc[1]; m1_stb = stb[1]; m1_we = we[1]; m1_sel = sel[1]; m1_adr = adr[1]; m1_dati = dat[1];
      s_ack  = ($urandom_range(0, 5) == 0);
      s_dati = $urandom;
      clr    = ($urandom_range(0, 7) == 0);
      #1;
      // A transfer is cut off on its T-th strobed cycle without an ack.
      abrt = (owner != 0) && stb[owner-1] && (waited == T - 1);
      eg = (owner == 0) ? 2'b00 : 2'(1 << (owner - 1));
      for (int k = 0; k < 2; k++) begin
        ea[k] = (owner == k + 1) && (abrt || s_ack);
        ed[k] = (owner != k + 1) ? 32'h0 : (abrt ? 32'hDEAD_BEEF : s_dati);
      end
      if (owner == 0)
        exp = {eg, flag, 3'b000, 4'h0, 64'h0, ea[0], ed[0], ea[1], ed[1]};
      else
        exp = {eg, flag, cyc[owner-1] && !abrt, stb[owner-1] && !abrt, we[owner-1],
               sel[owner-1], adr[owner-1], dat[owner-1], ea[0], ed[0], ea[1], ed[1]};
      obs = {grant, timeout, s_cyc, s_stb, s_we, s_sel, s_adr, s_dato, m0_ack, m0_dato, m1_ack, m1_dato};
      checks++; if (obs !== exp) begin errors++;
        $display("FAIL rand_cycle%0d: got %h required %h", n, obs, exp); end
      // Advance the model across the coming edge.
      if (abrt) flag = 1; else if (clr) flag = 0;
      if (owner == 0) begin
        winner = 0;
        if (cyc[0] && stb[0] && cyc[1] && stb[1]) winner = (last == 1) ? 2 : 1;
        else if (cyc[0] && stb[0])                winner = 1;
        else if (cyc[1] && stb[1])                winner = 2;
        if (winner != 0) begin owner = winner; last = winner; end
        waited = 0;
      end else if (abrt || !cyc[owner-1]) begin
        owner = 0; waited = 0;
      end else if (s_ack) begin
        waited = 0;
      end else if (stb[owner-1]) begin
        waited++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
